// File: rtl/pmp_fault_unit.sv
// pmp_fault_unit
// ---------------------------------------------------------------------------
// Catches PMP violations, latches the context of the first one and raises a
// held interrupt request towards the n-CLIC. The interrupt is retired either
// by the n-CLIC acknowledge or by software clearing the valid bit. Software
// inspects the captured context through three CSRs.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   fault_in    PMP violation level
//   fault_addr  faulting address
//   fault_op    opcode of the faulting access
//   fault_id    id of the running task
//   fault_prio  current interrupt priority
//   irq_ack     n-CLIC accepted the request (1-cycle pulse)
//   csr_enable  CSR access valid
//   csr_addr    CSR address
//   csr_we      CSR write strobe, qualified by csr_enable
//   csr_wdata   CSR write data
//   csr_rdata   CSR read data (combinational)
//   irq_out     fault interrupt request to the n-CLIC
//
// CSR map
//   BaseAddr+0  STATUS  {16'0, count, 5'0, acked, overflow, valid}
//                       write: bit0 W1C valid, bit1 W1C overflow,
//                              bit31 clears the fault counter
//   BaseAddr+1  ADDR    {16'0, addr}                (read only)
//   BaseAddr+2  INFO    {8'0, prio, id, 1'b0, op}   (read only)
// ---------------------------------------------------------------------------
module pmp_fault_unit #(
    parameter logic [11:0] BaseAddr   = 12'h401,
    parameter int          CountWidth = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fault_in,
    input  logic [15:0] fault_addr,
    input  logic [6:0]  fault_op,
    input  logic [7:0]  fault_id,
    input  logic [7:0]  fault_prio,
    input  logic        irq_ack,
    input  logic        csr_enable,
    input  logic [11:0] csr_addr,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        irq_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACKED   = 2'd2
    } state_t;

    localparam logic [CountWidth-1:0] CountMax = {CountWidth{1'b1}};
    localparam logic [11:0] StatusAddr = BaseAddr;
    localparam logic [11:0] AddrAddr   = BaseAddr + 12'd1;
    localparam logic [11:0] InfoAddr   = BaseAddr + 12'd2;

    state_t                state;
    state_t                state_next;
    logic                  capture;
    logic                  fault_q;
    logic                  fault_evt;
    logic [15:0]           addr_q;
    logic [6:0]            op_q;
    logic [7:0]            id_q;
    logic [7:0]            prio_q;
    logic                  overflow;
    logic [CountWidth-1:0] count;
    logic                  valid;
    logic                  acked;
    logic                  status_wr;
    logic                  valid_clr;
    logic                  ovf_clr;
    logic                  count_clr;
    logic                  ovf_set;
    logic [31:0]           status_word;
    logic                  unused_wdata;

    // Rising edge of the fault level: a long violation is a single event.
    assign fault_evt = fault_in & ~fault_q;

    // Only STATUS is writable; ADDR and INFO ignore writes.
    assign status_wr = csr_enable & csr_we & (csr_addr == StatusAddr);
    assign valid_clr = status_wr & csr_wdata[0];
    assign ovf_clr   = status_wr & csr_wdata[1];
    assign count_clr = status_wr & csr_wdata[31];
    assign unused_wdata = ^csr_wdata[30:2];

    // A further fault while one is held marks overflow, except when software
    // releases the held fault in the same cycle: then the new fault simply
    // becomes the captured one.
    assign ovf_set = (state != IDLE) & ~valid_clr & fault_evt;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A software valid-clear takes precedence over an
    // acknowledge arriving in the same cycle; a fault coinciding with the
    // clear re-arms the request with the new context.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (fault_evt) begin
                    state_next = PENDING;
                    capture    = 1'b1;
                end
            end
            PENDING: begin
                if (valid_clr) begin
                    if (fault_evt) begin
                        state_next = PENDING;
                        capture    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (irq_ack) begin
                    state_next = ACKED;
                end
            end
            ACKED: begin
                if (valid_clr) begin
                    if (fault_evt) begin
                        state_next = PENDING;
                        capture    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic: everything visible is decoded from the state register.
    always_comb begin
        irq_out = (state == PENDING);
        valid   = (state != IDLE);
        acked   = (state == ACKED);
    end

    // Edge register, captured context, overflow flag and fault counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q  <= 1'b0;
            addr_q   <= '0;
            op_q     <= '0;
            id_q     <= '0;
            prio_q   <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end else begin
            fault_q <= fault_in;
            if (capture) begin
                addr_q <= fault_addr;
                op_q   <= fault_op;
                id_q   <= fault_id;
                prio_q <= fault_prio;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            // A clear coinciding with a new fault leaves that fault counted.
            if (count_clr) begin
                count <= fault_evt ? CountWidth'(1) : '0;
            end else if (fault_evt && count != CountMax) begin
                count <= count + CountWidth'(1);
            end
        end
    end

    // Combinational CSR read port; reads have no side effects.
    always_comb begin
        status_word = (32'(count) << 8) | {29'b0, acked, overflow, valid};
        csr_rdata   = '0;
        if (csr_enable) begin
            case (csr_addr)
                StatusAddr: csr_rdata = status_word;
                AddrAddr:   csr_rdata = {16'b0, addr_q};
                InfoAddr:   csr_rdata = {8'b0, prio_q, id_q, 1'b0, op_q};
                default:    csr_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_fault_unit.sv
// Testbench for pmp_fault_unit: directed scenarios with fixed expectations
// followed by a randomized run compared against a flag-level reference model.
module tb_pmp_fault_unit;

    localparam logic [11:0] BASE = 12'h401;

    logic        clk;
    logic        reset;
    logic        fault_in;
    logic [15:0] fault_addr;
    logic [6:0]  fault_op;
    logic [7:0]  fault_id;
    logic [7:0]  fault_prio;
    logic        irq_ack;
    logic        csr_enable;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        irq_out;

    int checks   = 0;
    int failures = 0;

    // Reference model: the observable facts the unit keeps
    bit          m_prev;
    bit          m_valid;
    bit          m_acked;
    bit          m_ovf;
    int          m_count;
    logic [15:0] m_addr;
    logic [6:0]  m_op;
    logic [7:0]  m_id;
    logic [7:0]  m_prio;

    pmp_fault_unit #(.BaseAddr(BASE), .CountWidth(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .fault_in   (fault_in),
        .fault_addr (fault_addr),
        .fault_op   (fault_op),
        .fault_id   (fault_id),
        .fault_prio (fault_prio),
        .irq_ack    (irq_ack),
        .csr_enable (csr_enable),
        .csr_addr   (csr_addr),
        .csr_we     (csr_we),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .irq_out    (irq_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit evt, wr, vclr, oclr, cclr, was_valid;
        if (reset) begin
            m_prev = 0; m_valid = 0; m_acked = 0; m_ovf = 0; m_count = 0;
            m_addr = '0; m_op = '0; m_id = '0; m_prio = '0;
            return;
        end
        evt  = fault_in && !m_prev;
        wr   = csr_enable && csr_we && (csr_addr == BASE);
        vclr = wr && csr_wdata[0];
        oclr = wr && csr_wdata[1];
        cclr = wr && csr_wdata[31];
        was_valid = m_valid;
        if (cclr) m_count = evt ? 1 : 0;
        else if (evt && m_count < 255) m_count = m_count + 1;
        if (oclr) m_ovf = 0;
        if (was_valid && !vclr && evt) m_ovf = 1;
        if (!was_valid || vclr) begin
            if (evt) begin
                m_valid = 1; m_acked = 0;
                m_addr = fault_addr; m_op = fault_op; m_id = fault_id; m_prio = fault_prio;
            end else begin
                m_valid = 0; m_acked = 0;
            end
        end else if (!m_acked && irq_ack) begin
            m_acked = 1;
        end
        m_prev = fault_in;
    endtask

    function automatic logic [31:0] model_read(input logic en, input logic [11:0] a);
        if (!en) return 32'h0;
        if (a == BASE)     return {16'h0, 8'(m_count), 5'h0, m_acked, m_ovf, m_valid};
        if (a == BASE + 1) return {16'h0, m_addr};
        if (a == BASE + 2) return {8'h0, m_prio, m_id, 1'b0, m_op};
        return 32'h0;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
        csr_enable = 1'b1; csr_we = 1'b0; csr_addr = a;
        #1;
        d = csr_rdata;
        csr_enable = 1'b0; csr_addr = '0;
    endtask

    task automatic set_fault(input logic lvl, input logic [15:0] a, input logic [6:0] op,
                             input logic [7:0] id, input logic [7:0] pr);
        fault_in = lvl; fault_addr = a; fault_op = op; fault_id = id; fault_prio = pr;
    endtask

    // Arms a STATUS write that lands on the next tick.
    task automatic arm_status_write(input logic [31:0] d);
        csr_enable = 1'b1; csr_we = 1'b1; csr_addr = BASE; csr_wdata = d;
    endtask

    task automatic disarm_write();
        csr_enable = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1; fault_in = 0; irq_ack = 0; disarm_write();
        set_fault(0, 16'h0, 7'h0, 8'h0, 8'h0);
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (irq_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq got=%b exp=0", irq_out); end
        for (int i = 0; i < 3; i++) begin
            csr_read(BASE + 12'(i), d);
            checks++;
            if (d !== 32'h0) begin failures++; $display("[TB] FAIL reset_csr%0d got=%h exp=00000000", i, d); end
        end
    endtask

    task automatic test_capture();
        logic [31:0] d;
        do_reset();
        set_fault(1, 16'h1234, 7'b0000011, 8'h04, 8'h02);
        #1;
        checks++;
        if (irq_out !== 1'b0) begin failures++; $display("[TB] FAIL cap_latency got=%b exp=0", irq_out); end
        tick();
        checks++;
        if (irq_out !== 1'b1) begin failures++; $display("[TB] FAIL cap_irq got=%b exp=1", irq_out); end
        csr_read(BASE, d);
        checks++;
        if (d !== 32'h101) begin failures++; $display("[TB] FAIL cap_status got=%h exp=00000101", d); end
        csr_read(BASE + 1, d);
        checks++;
        if (d !== 32'h1234) begin failures++; $display("[TB] FAIL cap_addr got=%h exp=00001234", d); end
        csr_read(BASE + 2, d);
        checks++;
        if (d !== 32'h020403) begin failures++; $display("[TB] FAIL cap_info got=%h exp=00020403", d); end
        fault_in = 0;
        tick();
    endtask

    task automatic test_level_hold();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_fault(1, 16'h1000 + 16'(i), 7'h11, 8'h22, 8'h33);
            tick();
        end
        fault_in = 0;
        tick();
        csr_read(BASE, d);
        checks++;
        if (d !== 32'h101) begin failures++; $display("[TB] FAIL hold_status got=%h exp=00000101", d); end
        csr_read(BASE + 1, d);
        checks++;
        if (d !== 32'h1000) begin failures++; $display("[TB] FAIL hold_addr got=%h exp=00001000", d); end
    endtask

    task automatic test_ack_clear();
        logic [31:0] d;
        // continues from the pending fault left by test_level_hold
        irq_ack = 1; tick(); irq_ack = 0;
        checks++;
        if (irq_out !== 1'b0) begin failures++; $display("[TB] FAIL ack_irq got=%b exp=0", irq_out); end
        csr_read(BASE, d);
        checks++;
        if (d !== 32'h105) begin failures++; $display("[TB] FAIL ack_status got=%h exp=00000105", d); end
        arm_status_write(32'h1); tick(); disarm_write();
        csr_read(BASE, d);
        checks++;
        if (d !== 32'h100) begin failures++; $display("[TB] FAIL clr_status got=%h exp=00000100", d); end
        set_fault(1, 16'h5555, 7'h01, 8'h01, 8'h01); tick(); fault_in = 0;
        checks++;
        if (irq_out !== 1'b1) begin failures++; $display("[TB] FAIL clr_rearm_irq got=%b exp=1", irq_out); end
        csr_read(BASE + 1, d);
        checks++;
        if (d !== 32'h5555) begin failures++; $display("[TB] FAIL clr_rearm_addr got=%h exp=00005555", d); end
        tick();
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        do_reset();
        set_fault(1, 16'h1234, 7'h03, 8'h04, 8'h02); tick();
        fault_in = 0; tick();
        irq_ack = 1; tick(); irq_ack = 0;
        set_fault(1, 16'hBEEF, 7'h7F, 8'hAA, 8'hBB); tick();
        fault_in = 0; tick();
        csr_read(BASE + 1, d);
        checks++;
        if (d !== 32'h1234) begin failures++; $display("[TB] FAIL ovf_addr got=%h exp=00001234", d); end
        csr_read(BASE, d);
        checks++;
        if (d !== 32'h207) begin failures++; $display("[TB] FAIL ovf_status got=%h exp=00000207", d); end
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            set_fault(1, 16'(i), 7'h05, 8'h06, 8'h07); tick();
            fault_in = 0; tick();
        end
        csr_read(BASE, d);
        checks++;
        if (d !== 32'hFF03) begin failures++; $display("[TB] FAIL sat_status got=%h exp=0000ff03", d); end
        arm_status_write(32'h80000003); tick(); disarm_write();
        csr_read(BASE, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("[TB] FAIL sat_clear got=%h exp=00000000", d); end
        checks++;
        if (irq_out !== 1'b0) begin failures++; $display("[TB] FAIL sat_clear_irq got=%b exp=0", irq_out); end
    endtask

    task automatic test_reset_pending();
        logic [31:0] d;
        do_reset();
        set_fault(1, 16'hCAFE, 7'h13, 8'h09, 8'h0A); tick(); fault_in = 0;
        checks++;
        if (irq_out !== 1'b1) begin failures++; $display("[TB] FAIL rstp_pre got=%b exp=1", irq_out); end
        reset = 1; tick(); reset = 0;
        checks++;
        if (irq_out !== 1'b0) begin failures++; $display("[TB] FAIL rstp_irq got=%b exp=0", irq_out); end
        for (int i = 0; i < 3; i++) begin
            csr_read(BASE + 12'(i), d);
            checks++;
            if (d !== 32'h0) begin failures++; $display("[TB] FAIL rstp_csr%0d got=%h exp=00000000", i, d); end
        end
        set_fault(1, 16'h0ACE, 7'h23, 8'h11, 8'h12); tick(); fault_in = 0;
        checks++;
        if (irq_out !== 1'b1) begin failures++; $display("[TB] FAIL rstp_post_irq got=%b exp=1", irq_out); end
        csr_read(BASE + 2, d);
        checks++;
        if (d !== 32'h121123) begin failures++; $display("[TB] FAIL rstp_post_info got=%h exp=00121123", d); end
        tick();
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        do_reset();
        set_fault(1, 16'hA000, 7'h01, 8'h01, 8'h01); tick(); fault_in = 0; tick();
        set_fault(1, 16'hB000, 7'h02, 8'h02, 8'h02); tick(); fault_in = 0; tick();
        // clear + new fault: new context captured, overflow kept
        set_fault(1, 16'hC000, 7'h03, 8'h03, 8'h03); arm_status_write(32'h1); tick();
        disarm_write(); fault_in = 0;
        checks++;
        if (irq_out !== 1'b1) begin failures++; $display("[TB] FAIL sim_clr_irq got=%b exp=1", irq_out); end
        csr_read(BASE + 1, d);
        checks++;
        if (d !== 32'hC000) begin failures++; $display("[TB] FAIL sim_clr_addr got=%h exp=0000c000", d); end
        csr_read(BASE, d);
        checks++;
        if (d !== 32'h303) begin failures++; $display("[TB] FAIL sim_clr_status got=%h exp=00000303", d); end
        tick();
        // clear + overflow clear + new fault
        set_fault(1, 16'hD000, 7'h04, 8'h04, 8'h04); arm_status_write(32'h3); tick();
        disarm_write(); fault_in = 0;
        csr_read(BASE, d);
        checks++;
        if (d !== 32'h401) begin failures++; $display("[TB] FAIL sim_clr2_status got=%h exp=00000401", d); end
        tick();
        // ack + new fault: acked with overflow, context kept
        set_fault(1, 16'hE000, 7'h05, 8'h05, 8'h05); irq_ack = 1; tick();
        irq_ack = 0; fault_in = 0;
        checks++;
        if (irq_out !== 1'b0) begin failures++; $display("[TB] FAIL sim_ack_irq got=%b exp=0", irq_out); end
        csr_read(BASE, d);
        checks++;
        if (d !== 32'h507) begin failures++; $display("[TB] FAIL sim_ack_status got=%h exp=00000507", d); end
        csr_read(BASE + 1, d);
        checks++;
        if (d !== 32'hD000) begin failures++; $display("[TB] FAIL sim_ack_addr got=%h exp=0000d000", d); end
        tick();
        // count clear + new fault leaves count at one
        set_fault(1, 16'hF000, 7'h06, 8'h06, 8'h06); arm_status_write(32'h80000000); tick();
        disarm_write(); fault_in = 0;
        csr_read(BASE, d);
        checks++;
        if (d !== 32'h107) begin failures++; $display("[TB] FAIL sim_cnt_status got=%h exp=00000107", d); end
        tick();
    endtask

    task automatic test_csr_decode();
        logic [31:0] d;
        do_reset();
        irq_ack = 1; tick(); irq_ack = 0;
        set_fault(1, 16'h7777, 7'h07, 8'h08, 8'h09); tick(); fault_in = 0;
        checks++;
        if (irq_out !== 1'b1) begin failures++; $display("[TB] FAIL dec_idle_ack got=%b exp=1", irq_out); end
        csr_enable = 1; csr_we = 1; csr_addr = BASE + 1; csr_wdata = 32'hFFFFFFFF; tick(); disarm_write();
        csr_read(BASE + 1, d);
        checks++;
        if (d !== 32'h7777) begin failures++; $display("[TB] FAIL dec_addr_ro got=%h exp=00007777", d); end
        csr_read(BASE + 3, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("[TB] FAIL dec_unmapped got=%h exp=00000000", d); end
        csr_addr = BASE; #1;
        checks++;
        if (csr_rdata !== 32'h0) begin failures++; $display("[TB] FAIL dec_disabled got=%h exp=00000000", csr_rdata); end
        csr_addr = '0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] exp;
        logic [11:0] addrs [4];
        addrs[0] = BASE; addrs[1] = BASE + 1; addrs[2] = BASE + 2; addrs[3] = 12'h123;
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) == 0) fault_in = ~fault_in;
            fault_addr = 16'($urandom); fault_op = 7'($urandom);
            fault_id   = 8'($urandom);  fault_prio = 8'($urandom);
            irq_ack    = ($urandom_range(0, 5) == 0);
            csr_enable = $urandom_range(0, 1);
            csr_addr   = addrs[$urandom_range(0, 3)];
            csr_we     = ($urandom_range(0, 3) == 0);
            csr_wdata  = $urandom & 32'h7FFFFFFF;
            if ($urandom_range(0, 15) == 0) csr_wdata[31] = 1'b1;
            #1;
            exp = model_read(csr_enable, csr_addr);
            checks++;
            if (csr_rdata !== exp) begin
                failures++;
                $display("[TB] FAIL rnd_rdata cycle=%0d got=%h exp=%h", i, csr_rdata, exp);
            end
            tick();
            checks++;
            if (irq_out !== (m_valid && !m_acked)) begin
                failures++;
                $display("[TB] FAIL rnd_irq cycle=%0d got=%b exp=%b", i, irq_out, m_valid && !m_acked);
            end
        end
        reset = 0; irq_ack = 0; fault_in = 0; disarm_write();
        tick();
    endtask

    initial begin
        reset = 1; fault_in = 0; irq_ack = 0;
        csr_enable = 0; csr_we = 0; csr_addr = '0; csr_wdata = '0;
        fault_addr = '0; fault_op = '0; fault_id = '0; fault_prio = '0;
        test_reset();
        test_capture();
        test_level_hold();
        test_ack_clear();
        test_overflow();
        test_saturation();
        test_reset_pending();
        test_simultaneous();
        test_csr_decode();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
